// File: rtl/register_pipe_pkg.sv
// rtl/register_pipe_pkg.sv - shared helpers for the elastic register pipe
package register_pipe_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/register_pipe_stage.sv
// rtl/register_pipe_stage.sv - one valid/data register pair of the elastic pipe
module register_pipe_stage #(
    parameter int               WIDTH     = 17,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             flush,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             v_out,
    output logic [WIDTH-1:0] d_out
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    // Data only moves with a real word, so a stalled or drained stage keeps its value.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush) begin
            v_d = 1'b0;
        end else if (load) begin
            v_d = v_in;
        end
        if (load && v_in) begin
            d_d = d_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q <= 1'b0;
            d_q <= RESET_VAL;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v_out = v_q;
    assign d_out = d_q;

endmodule

// File: rtl/register_pipe.sv
// rtl/register_pipe.sv - stallable multi-stage pipeline register with flush and occupancy
module register_pipe
    import register_pipe_pkg::*;
#(
    parameter int               WIDTH     = 17,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CW        = clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CW-1:0]    count
);

    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  d [STAGES];
    logic [STAGES:0]   r;
    logic [CW-1:0]     count_q, count_d;
    logic              in_xfer, out_xfer;

    // A stage may load whenever it is empty or everything below it drains this cycle.
    always_comb begin
        r         = '0;
        r[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            r[i] = !v[i] || r[i+1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_first
            register_pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
                .clk    (clk),
                .reset_n(reset_n),
                .load   (r[g]),
                .flush  (flush),
                .v_in   (in_valid),
                .d_in   (in_data),
                .v_out  (v[g]),
                .d_out  (d[g])
            );
        end else begin : g_next
            register_pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
                .clk    (clk),
                .reset_n(reset_n),
                .load   (r[g]),
                .flush  (flush),
                .v_in   (v[g-1]),
                .d_in   (d[g-1]),
                .v_out  (v[g]),
                .d_out  (d[g])
            );
        end
    end

    assign in_ready  = r[0] && !flush;
    assign out_valid = v[STAGES-1];
    assign out_data  = d[STAGES-1];
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(in_xfer) - CW'(out_xfer);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_register_pipe.sv
// tb/tb_register_pipe.sv - self-checking bench for register_pipe at three geometries
module tb_register_pipe;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [16:0] in_data;
    logic        out_ready;
    logic        flush;

    logic        ov_a [3];
    logic        ir_a [3];
    logic [16:0] od_a [3];
    logic [2:0]  cn_a [3];
    logic [16:0] rv_a [3];

    int vec_cnt = 0;
    int miss_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar K = 0; K < 3; K++) begin : g
        localparam int STG = (K == 0) ? 2 : (K == 1) ? 1 : 4;
        localparam int W   = (K == 0) ? 17 : 8;
        localparam int CWK = (STG == 1) ? 1 : (STG == 2) ? 2 : 3;
        localparam logic [W-1:0] RV = (K == 0) ? W'(0) : (K == 1) ? W'(8'hA5) : W'(8'h3C);

        logic           ov, ir;
        logic [W-1:0]   od;
        logic [CWK-1:0] cn;

        register_pipe #(.WIDTH(W), .STAGES(STG), .RESET_VAL(RV)) dut (
            .clk      (clk),
            .reset_n  (reset_n),
            .in_valid (in_valid),
            .in_ready (ir),
            .in_data  (in_data[W-1:0]),
            .out_valid(ov),
            .out_ready(out_ready),
            .out_data (od),
            .flush    (flush),
            .count    (cn)
        );

        assign ov_a[K] = ov;
        assign ir_a[K] = ir;
        assign od_a[K] = 17'(od);
        assign cn_a[K] = 3'(cn);
        assign rv_a[K] = 17'(RV);

        // Model: queue of words, oldest first, each with its stage position.
        logic [16:0] qw [$];
        int          qp [$];

        function automatic int last_pos(input bit ordy);
            int lim;
            int np;
            int k0;
            lim = STG;
            np  = STG;
            k0  = 0;
            if (qp.size() > 0 && qp[0] == STG - 1 && ordy) k0 = 1;
            for (int k = k0; k < qp.size(); k++) begin
                np  = (qp[k] + 1 < lim) ? qp[k] + 1 : lim - 1;
                lim = np;
            end
            return np;
        endfunction

        always @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                qw.delete();
                qp.delete();
            end else begin
                bit acc;
                int lim;
                acc = !flush && in_valid && (last_pos(out_ready) > 0);
                if (qp.size() > 0 && qp[0] == STG - 1 && out_ready) begin
                    void'(qw.pop_front());
                    void'(qp.pop_front());
                end
                lim = STG;
                for (int k = 0; k < qp.size(); k++) begin
                    qp[k] = (qp[k] + 1 < lim) ? qp[k] + 1 : lim - 1;
                    lim   = qp[k];
                end
                if (flush) begin
                    qw.delete();
                    qp.delete();
                end else if (acc) begin
                    qw.push_back(17'(in_data[W-1:0]));
                    qp.push_back(0);
                end
            end
        end

        always @(negedge clk) begin
            if (reset_n) begin
                bit eov;
                eov = qp.size() > 0 && qp[0] == STG - 1;
                chk($sformatf("k%0d model in_ready", K), ir_a[K], !flush && (last_pos(out_ready) > 0));
                chk($sformatf("k%0d model out_valid", K), ov_a[K], eov);
                if (eov) chk($sformatf("k%0d model out_data", K), od_a[K], qw[0]);
                chk($sformatf("k%0d model count", K), cn_a[K], qw.size());
            end
        end
    end

    task automatic drive(input bit iv, input logic [16:0] dd, input bit ordy, input bit fl);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = dd;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic chk_reset_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s k%0d out_valid", tag, k), ov_a[k], 0);
            chk($sformatf("%s k%0d out_data", tag, k), od_a[k], rv_a[k]);
            chk($sformatf("%s k%0d count", tag, k), cn_a[k], 0);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_all("reset");
        for (int k = 0; k < 3; k++) chk($sformatf("reset k%0d in_ready", k), ir_a[k], 1);
        reset_n = 1'b1;

        // Streaming with out_ready high
        drive(1, 17'h00001, 1, 0);
        drive(1, 17'h00002, 1, 0);
        chk("stream k0 out_valid early", ov_a[0], 0);
        chk("stream k1 out_valid", ov_a[1], 1);
        chk("stream k1 out_data", od_a[1], 17'h00001);
        drive(1, 17'h00003, 1, 0);
        chk("stream k0 out_valid", ov_a[0], 1);
        chk("stream k0 out_data", od_a[0], 17'h00001);
        chk("stream k0 count peak", cn_a[0], 2);
        drive(1, 17'h00004, 1, 0);
        drive(1, 17'h00005, 1, 0);
        repeat (6) drive(0, 17'h0, 1, 0);

        // Fill then stall
        drive(1, 17'h1ABCD, 0, 0);
        drive(1, 17'h00042, 0, 0);
        chk("stall k0 in_ready second", ir_a[0], 1);
        drive(1, 17'h0FFFF, 0, 0);
        chk("stall k0 in_ready full", ir_a[0], 0);
        chk("stall k0 count", cn_a[0], 2);
        chk("stall k0 out_data", od_a[0], 17'h1ABCD);
        drive(1, 17'h0FFFF, 0, 0);
        chk("stall k0 out_data held", od_a[0], 17'h1ABCD);
        repeat (8) drive(0, 17'h0, 1, 0);

        // Bubble collapse
        drive(1, 17'h11111, 0, 0);
        drive(0, 17'h0, 0, 0);
        drive(1, 17'h12345, 0, 0);
        chk("bubble k0 in_ready", ir_a[0], 1);
        drive(0, 17'h0, 0, 0);
        chk("bubble k0 count", cn_a[0], 2);
        chk("bubble k0 out_data", od_a[0], 17'h11111);
        repeat (8) drive(0, 17'h0, 1, 0);

        // Full with continuous flow
        drive(1, 17'h00100, 0, 0);
        drive(1, 17'h00101, 0, 0);
        for (int i = 0; i < 10; i++) begin
            logic [16:0] e;
            e = (i == 0) ? 17'h00100 : (i == 1) ? 17'h00101 : 17'(17'h00200 + i - 2);
            drive(1, 17'(17'h00200 + i), 1, 0);
            chk($sformatf("flow k0 count i%0d", i), cn_a[0], 2);
            chk($sformatf("flow k0 in_ready i%0d", i), ir_a[0], 1);
            chk($sformatf("flow k0 out_data i%0d", i), od_a[0], e);
        end

        // Flush with full pipe and input offered
        drive(1, 17'h0DEAD, 0, 1);
        for (int k = 0; k < 3; k++) chk($sformatf("flush k%0d in_ready", k), ir_a[k], 0);
        chk("flush k0 count before", cn_a[0], 2);
        drive(0, 17'h0, 1, 0);
        chk("flush k0 out_valid after", ov_a[0], 0);
        chk("flush k0 count after", cn_a[0], 0);
        repeat (4) drive(0, 17'h0, 1, 0);

        // Asynchronous reset pulse between edges
        drive(1, 17'h00077, 0, 0);
        drive(0, 17'h0, 0, 0);
        for (int k = 0; k < 3; k++) chk($sformatf("pre-pulse k%0d count", k), cn_a[k], 1);
        chk("pre-pulse k1 out_valid", ov_a[1], 1);
        #1 reset_n = 1'b0;
        #1 chk_reset_all("pulse");
        #1 reset_n = 1'b1;
        drive(1, 17'h00055, 1, 0);
        repeat (6) drive(0, 17'h0, 1, 0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
